// File: rtl/sel_mux_reg.sv
// sel_mux_reg: registered channel selector with debounced selector code.
//
// Picks one of CH channels (WIDTH bits each) when the adopted selector code
// is an enable pattern (upper SEL_W-IDX_W bits all ones). Otherwise it emits
// the constant FALLBACK word. A new selector code is adopted only after
// STABLE consecutive identical samples. The result sits in a one-entry
// valid/ready output register.
//
// Ports:
//   clk, rst    rising-edge clock, synchronous active-high reset
//   in_data     CH*WIDTH packed channels, channel k at [k*WIDTH +: WIDTH]
//   in_valid    input word available
//   in_ready    block accepts input this cycle
//   sel         selector code
//   out_data    registered result
//   out_valid   out_data valid
//   out_ready   consumer accepts out_data
//   out_src     channel index that produced out_data (0 for fallback)
//   out_fb      out_data is FALLBACK
//   sel_busy    a selector change is still being qualified
//   fb_cnt      (only with FB_CNT_EN) saturating count of fallback captures
//
// Optional feature macro: FB_CNT_EN adds the fb_cnt port and its counter.

module sel_mux_reg #(
    parameter int unsigned      WIDTH    = 4,
    parameter int unsigned      CH       = 4,
    parameter int unsigned      SEL_W    = 6,
    parameter logic [WIDTH-1:0] FALLBACK = 4'b0101,
    parameter int unsigned      STABLE   = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [CH*WIDTH-1:0]     in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [SEL_W-1:0]        sel,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [$clog2(CH)-1:0]   out_src,
    output logic                    out_fb,
`ifdef FB_CNT_EN
    output logic                    sel_busy,
    output logic [15:0]             fb_cnt
`else
    output logic                    sel_busy
`endif
);

    localparam int unsigned IDX_W = $clog2(CH);
    localparam int unsigned CNT_W = $clog2(STABLE + 1);

    typedef enum logic {
        MODE_FB   = 1'b0,
        MODE_PASS = 1'b1
    } mode_e;

    // Selector qualification state
    logic [SEL_W-1:0] cand_q, cand_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SEL_W-1:0] act_q, act_d;
    mode_e            mode_q, mode_d;

    // Output register state
    logic [WIDTH-1:0] data_q, data_d;
    logic [IDX_W-1:0] src_q, src_d;
    logic             fb_q, fb_d;
    logic             valid_q, valid_d;

    logic             capture;
    logic [WIDTH-1:0] ch_data;

`ifdef FB_CNT_EN
    logic [15:0]      fb_cnt_q, fb_cnt_d;
`endif

    // Qualifier: act adopts cand on the edge where the run of identical
    // samples reaches STABLE; mode changes only together with act.
    always_comb begin
        cand_d = cand_q;
        cnt_d  = cnt_q;
        act_d  = act_q;
        mode_d = mode_q;
        if (sel != cand_q) begin
            cand_d = sel;
            cnt_d  = CNT_W'(1);
        end else if (cnt_q < CNT_W'(STABLE)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        if ((cnt_d == CNT_W'(STABLE)) && (cand_d != act_q)) begin
            act_d  = cand_d;
            mode_d = (&cand_d[SEL_W-1:IDX_W]) ? MODE_PASS : MODE_FB;
        end
    end

    // Channel extraction for the currently adopted index
    always_comb begin
        ch_data = FALLBACK;
        for (int unsigned k = 0; k < CH; k++) begin
            if (act_q[IDX_W-1:0] == IDX_W'(k)) begin
                ch_data = in_data[k*WIDTH +: WIDTH];
            end
        end
    end

    // Output register: capture uses the mode registered before this edge
    always_comb begin
        in_ready = !valid_q || out_ready;
        capture  = in_valid && in_ready;
        data_d   = data_q;
        src_d    = src_q;
        fb_d     = fb_q;
        valid_d  = valid_q;
        if (capture) begin
            valid_d = 1'b1;
            if (mode_q == MODE_PASS) begin
                data_d = ch_data;
                src_d  = act_q[IDX_W-1:0];
                fb_d   = 1'b0;
            end else begin
                data_d = FALLBACK;
                src_d  = '0;
                fb_d   = 1'b1;
            end
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

`ifdef FB_CNT_EN
    // Saturating count of captures taken in fallback mode
    always_comb begin
        fb_cnt_d = fb_cnt_q;
        if (capture && (mode_q == MODE_FB) && (fb_cnt_q != 16'hFFFF)) begin
            fb_cnt_d = fb_cnt_q + 16'd1;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            cand_q   <= '0;
            cnt_q    <= '0;
            act_q    <= '0;
            mode_q   <= MODE_FB;
            data_q   <= FALLBACK;
            src_q    <= '0;
            fb_q     <= 1'b1;
            valid_q  <= 1'b0;
`ifdef FB_CNT_EN
            fb_cnt_q <= '0;
`endif
        end else begin
            cand_q   <= cand_d;
            cnt_q    <= cnt_d;
            act_q    <= act_d;
            mode_q   <= mode_d;
            data_q   <= data_d;
            src_q    <= src_d;
            fb_q     <= fb_d;
            valid_q  <= valid_d;
`ifdef FB_CNT_EN
            fb_cnt_q <= fb_cnt_d;
`endif
        end
    end

    assign out_data  = data_q;
    assign out_src   = src_q;
    assign out_fb    = fb_q;
    assign out_valid = valid_q;
    assign sel_busy  = (cand_q != act_q) || (sel != cand_q);
`ifdef FB_CNT_EN
    assign fb_cnt    = fb_cnt_q;
`endif

endmodule

// File: tb/tb_sel_mux_reg.sv
// Self-checking bench for sel_mux_reg (default parameters).
module tb_sel_mux_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  sel;
    logic [3:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_src;
    logic        out_fb;
    logic        sel_busy;
`ifdef FB_CNT_EN
    logic [15:0] fb_cnt;
`endif

    int checks = 0;
    int errors = 0;

    sel_mux_reg dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sel       (sel),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_src   (out_src),
        .out_fb    (out_fb),
`ifdef FB_CNT_EN
        .sel_busy  (sel_busy),
        .fb_cnt    (fb_cnt)
`else
        .sel_busy  (sel_busy)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: act is adopted once the current selector value has
    // been seen on STABLE consecutive edges since reset.
    localparam int STABLE = 2;

    typedef struct {
        logic [3:0] d;
        logic [1:0] s;
        logic       f;
    } exp_t;

    exp_t       sb[$];
    logic       mon_en = 1'b0;
    logic [5:0] m_last = '0;
    logic [5:0] m_act  = '0;
    int         m_run  = 0;

    // Scoreboard monitor: compares before the edge, then advances the model
    always @(negedge clk) begin
        exp_t       e;
        logic       exp_ready;
        logic       exp_busy;
        logic [1:0] idx;
        if (mon_en) begin
            exp_ready = (sb.size() == 0) || (out_ready === 1'b1);
            exp_busy  = (sel != m_last) || (m_last != m_act);

            checks++;
            if (out_valid !== (sb.size() != 0)) begin
                errors++;
                $display("FAIL sb_out_valid t=%0t got %b want %b", $time, out_valid, sb.size() != 0);
            end
            checks++;
            if (in_ready !== exp_ready) begin
                errors++;
                $display("FAIL sb_in_ready t=%0t got %b want %b", $time, in_ready, exp_ready);
            end
            checks++;
            if (sel_busy !== exp_busy) begin
                errors++;
                $display("FAIL sb_sel_busy t=%0t got %b want %b", $time, sel_busy, exp_busy);
            end
            if (out_valid === 1'b1 && sb.size() != 0) begin
                checks++;
                if (out_data !== sb[0].d || out_src !== sb[0].s || out_fb !== sb[0].f) begin
                    errors++;
                    $display("FAIL sb_word t=%0t got d=%h s=%0d f=%b want d=%h s=%0d f=%b",
                             $time, out_data, out_src, out_fb, sb[0].d, sb[0].s, sb[0].f);
                end
            end

            if (rst) begin
                sb.delete();
                m_last = '0;
                m_act  = '0;
                m_run  = 0;
            end else begin
                if (out_ready && sb.size() != 0) void'(sb.pop_front());
                if (in_valid && exp_ready) begin
                    if (m_act[5:2] == 4'hF) begin
                        idx = m_act[1:0];
                        e.d = in_data[int'(idx)*4 +: 4];
                        e.s = idx;
                        e.f = 1'b0;
                    end else begin
                        e.d = 4'b0101;
                        e.s = 2'd0;
                        e.f = 1'b1;
                    end
                    sb.push_back(e);
                end
                m_run  = (sel == m_last) ? ((m_run < 100) ? m_run + 1 : m_run) : 1;
                m_last = sel;
                if (m_run >= STABLE) m_act = sel;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        sel       = 6'b000000;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        in_data   = 16'hA5C3;
        tick();
        mon_en = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_data !== 4'b0101 || out_fb !== 1'b1 || out_src !== 2'd0) begin
            errors++;
            $display("FAIL reset_state got v=%b d=%h fb=%b src=%0d want v=0 d=5 fb=1 src=0",
                     out_valid, out_data, out_fb, out_src);
        end
        tick();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_data !== 4'b0101 || out_fb !== 1'b1 || out_src !== 2'd0) begin
                errors++;
                $display("FAIL fallback_stream cyc=%0d got v=%b d=%h fb=%b src=%0d want v=1 d=5 fb=1 src=0",
                         i, out_valid, out_data, out_fb, out_src);
            end
            tick();
        end
    endtask

    task automatic test_glitch();
        for (int i = 0; i < 10; i++) begin
            sel = (i % 2 == 0) ? 6'b111110 : 6'b000000;
            @(negedge clk);
            checks++;
            if (sel_busy !== 1'b1 || out_fb !== 1'b1) begin
                errors++;
                $display("FAIL glitch cyc=%0d got busy=%b fb=%b want busy=1 fb=1", i, sel_busy, out_fb);
            end
            tick();
        end
        sel = 6'b000000;
        repeat (3) tick();
    endtask

    task automatic test_pass();
        int busy_n = 0;
        sel     = 6'b111111;
        in_data = 16'hA5C3;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (sel_busy === 1'b1) begin
                busy_n++;
                checks++;
                if (out_fb !== 1'b1) begin
                    errors++;
                    $display("FAIL pass_early_capture cyc=%0d got fb=%b want 1", i, out_fb);
                end
            end
            tick();
        end
        checks++;
        if (busy_n != 2) begin
            errors++;
            $display("FAIL pass_busy_cycles got %0d want 2", busy_n);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 4'hA || out_src !== 2'd3 || out_fb !== 1'b0) begin
            errors++;
            $display("FAIL pass_word got v=%b d=%h src=%0d fb=%b want v=1 d=a src=3 fb=0",
                     out_valid, out_data, out_src, out_fb);
        end
        tick();
    endtask

    task automatic test_backpressure();
        logic [3:0] frozen;
        logic [3:0] rel;
        sel = 6'b111101;
        for (int i = 0; i < 5; i++) begin
            in_data = 16'($urandom);
            tick();
        end
        out_ready = 1'b0;
        in_data   = 16'($urandom);
        frozen    = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (i == 0) frozen = out_data;
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== frozen || out_src !== 2'd1) begin
                errors++;
                $display("FAIL stall cyc=%0d got rdy=%b v=%b d=%h src=%0d want rdy=0 v=1 d=%h src=1",
                         i, in_ready, out_valid, out_data, out_src, frozen);
            end
            tick();
            in_data = 16'($urandom);
        end
        out_ready = 1'b1;
        rel = in_data[7:4];
        @(negedge clk);
        checks++;
        if (out_data !== frozen || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL release got d=%h rdy=%b want d=%h rdy=1", out_data, in_ready, frozen);
        end
        tick();
        in_data = 16'($urandom);
        @(negedge clk);
        checks++;
        if (out_data !== rel || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL after_release got d=%h v=%b want d=%h v=1", out_data, out_valid, rel);
        end
        tick();
        for (int i = 0; i < 4; i++) begin
            in_data = 16'($urandom);
            tick();
        end
    endtask

    task automatic test_reset_mid();
        int busy_n = 0;
        in_data   = 16'hA5C3;
        out_ready = 1'b0;
        sel       = 6'b111111;
        tick();
        rst = 1'b1;
        tick();
        rst       = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 0) begin
                checks++;
                if (out_valid !== 1'b0 || out_data !== 4'b0101 || out_fb !== 1'b1 || out_src !== 2'd0) begin
                    errors++;
                    $display("FAIL mid_reset got v=%b d=%h fb=%b src=%0d want v=0 d=5 fb=1 src=0",
                             out_valid, out_data, out_fb, out_src);
                end
            end
            if (sel_busy === 1'b1) busy_n++;
            tick();
        end
        checks++;
        if (busy_n != 2) begin
            errors++;
            $display("FAIL mid_reset_requal got %0d want 2", busy_n);
        end
    endtask

`ifdef FB_CNT_EN
    task automatic test_fb_cnt();
        in_valid = 1'b0;
        sel      = 6'b000000;
        rst      = 1'b1;
        tick();
        rst = 1'b0;
        in_valid = 1'b1;
        repeat (5) tick();
        in_valid = 1'b0;
        sel = 6'b111111;
        repeat (4) tick();
        in_valid = 1'b1;
        repeat (3) tick();
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (fb_cnt !== 16'd5) begin
            errors++;
            $display("FAIL fb_cnt got %h want 0005", fb_cnt);
        end
        tick();
        sel = 6'b000000;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        force dut.fb_cnt_q = 16'hFFFE;
        tick();
        release dut.fb_cnt_q;
        in_valid = 1'b1;
        repeat (3) tick();
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (fb_cnt !== 16'hFFFF) begin
            errors++;
            $display("FAIL fb_cnt_sat got %h want ffff", fb_cnt);
        end
        tick();
    endtask
`endif

    task automatic test_drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || sb.size() != 0) begin
            errors++;
            $display("FAIL drain got v=%b pending=%0d want v=0 pending=0", out_valid, sb.size());
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_pass();
        test_backpressure();
        test_reset_mid();
`ifdef FB_CNT_EN
        test_fb_cnt();
`endif
        test_drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
